// File: rtl/mem_arbiter_if.sv
`default_nettype none
// ============================================================================
//  Module      : mem_arbiter_if
//  Description : Bundle of every handshake/bus signal around mem_arbiter:
//                hart fetch port, hart data port and backing-memory port.
//                slave  - the arbiter side (drives responses and memory cmd)
//                master - the hart + memory side (drives requests and memory
//                         responses)
//  Revision    : 1.0 - initial release
// ============================================================================
interface mem_arbiter_if;
    // Fetch port
    logic        i_if_req;
    logic [31:0] i_if_addr;
    logic        o_if_ready;
    logic        o_if_valid;
    logic [31:0] o_if_rdata;
    // Data port
    logic        i_d_req;
    logic [31:0] i_d_addr;
    logic        i_d_ren;
    logic        i_d_wen;
    logic [31:0] i_d_wdata;
    logic [3:0]  i_d_mask;
    logic        o_d_ready;
    logic        o_d_valid;
    logic [31:0] o_d_rdata;
    logic        o_d_err;
    // Backing memory port
    logic        o_mem_ren;
    logic        o_mem_wen;
    logic [31:0] o_mem_addr;
    logic [31:0] o_mem_wdata;
    logic [3:0]  o_mem_mask;
    logic        i_mem_ready;
    logic        i_mem_valid;
    logic [31:0] i_mem_rdata;
    // Status
    logic        o_busy;

    modport slave (
        input  i_if_req, i_if_addr,
        output o_if_ready, o_if_valid, o_if_rdata,
        input  i_d_req, i_d_addr, i_d_ren, i_d_wen, i_d_wdata, i_d_mask,
        output o_d_ready, o_d_valid, o_d_rdata, o_d_err,
        output o_mem_ren, o_mem_wen, o_mem_addr, o_mem_wdata, o_mem_mask,
        input  i_mem_ready, i_mem_valid, i_mem_rdata,
        output o_busy
    );

    modport master (
        output i_if_req, i_if_addr,
        input  o_if_ready, o_if_valid, o_if_rdata,
        output i_d_req, i_d_addr, i_d_ren, i_d_wen, i_d_wdata, i_d_mask,
        input  o_d_ready, o_d_valid, o_d_rdata, o_d_err,
        input  o_mem_ren, o_mem_wen, o_mem_addr, o_mem_wdata, o_mem_mask,
        output i_mem_ready, i_mem_valid, i_mem_rdata,
        input  o_busy
    );
endinterface
`default_nettype wire

// File: rtl/mem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : mem_arbiter
//  Description : Shares one handshaked backing memory between the hart's
//                instruction-fetch port and its data port. One transaction
//                outstanding at a time; data has priority, but after
//                MAX_DATA_BURST consecutive data grants with fetch waiting,
//                fetch is forced to win. Responses are routed to the
//                requester that owns the outstanding transaction.
//  Ports       : i_clk  - clock, rising edge
//                i_rst  - asynchronous active-high reset
//                bus    - mem_arbiter_if.slave (fetch, data, memory, busy)
//  Revision    : 1.0 - initial release
// ============================================================================
module mem_arbiter #(
    parameter int MAX_DATA_BURST = 4   // legal range 1..15
) (
    input  wire logic     i_clk,
    input  wire logic     i_rst,
    mem_arbiter_if.slave  bus
);

    localparam logic [3:0]  C_MAX_BURST = 4'(MAX_DATA_BURST);
    localparam logic [31:0] C_WORD_MASK = 32'hFFFF_FFFC;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,   // nothing latched
        S_ISSUE = 2'd1,   // command on the memory port until accepted
        S_WAIT  = 2'd2,   // accepted, waiting for the memory response
        S_ERR   = 2'd3    // illegal data request: error response this cycle
    } state_t;

    state_t      r_state;
    logic [3:0]  r_streak;
    logic        r_owner_d;      // 1: outstanding transaction belongs to data
    logic        r_mem_ren;
    logic        r_mem_wen;
    logic [31:0] r_mem_addr;
    logic [31:0] r_mem_wdata;
    logic [3:0]  r_mem_mask;

    logic w_grant_point;
    logic w_grant_d;
    logic w_grant_if;
    logic w_resp;
    logic w_d_illegal;

    // Arbitration happens when no transaction is held, or in the very cycle
    // the current one completes so back-to-back transfers lose no cycle.
    assign w_grant_point = (r_state == S_IDLE) || (r_state == S_ERR) ||
                           ((r_state == S_WAIT) && bus.i_mem_valid);

    // Ready pulses are combinational so a request is accepted in the cycle it
    // is first seen; they are held off while reset is asserted.
    assign w_grant_d  = !i_rst && w_grant_point && bus.i_d_req &&
                        (!bus.i_if_req || (r_streak != C_MAX_BURST));
    assign w_grant_if = !i_rst && w_grant_point && bus.i_if_req && !w_grant_d;

    assign w_resp      = (r_state == S_WAIT) && bus.i_mem_valid;
    assign w_d_illegal = bus.i_d_ren && bus.i_d_wen;

    assign bus.o_if_ready = w_grant_if;
    assign bus.o_d_ready  = w_grant_d;

    assign bus.o_if_valid = w_resp && !r_owner_d;
    assign bus.o_if_rdata = (w_resp && !r_owner_d) ? bus.i_mem_rdata : 32'h0;

    assign bus.o_d_valid  = (w_resp && r_owner_d) || (r_state == S_ERR);
    assign bus.o_d_rdata  = (w_resp && r_owner_d) ? bus.i_mem_rdata : 32'h0;
    assign bus.o_d_err    = (r_state == S_ERR);

    assign bus.o_mem_ren   = r_mem_ren;
    assign bus.o_mem_wen   = r_mem_wen;
    assign bus.o_mem_addr  = r_mem_addr;
    assign bus.o_mem_wdata = r_mem_wdata;
    assign bus.o_mem_mask  = r_mem_mask;
    assign bus.o_busy      = (r_state != S_IDLE);

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state     <= S_IDLE;
            r_streak    <= 4'd0;
            r_owner_d   <= 1'b0;
            r_mem_ren   <= 1'b0;
            r_mem_wen   <= 1'b0;
            r_mem_addr  <= 32'h0;
            r_mem_wdata <= 32'h0;
            r_mem_mask  <= 4'h0;
        end else if (r_state == S_ISSUE) begin
            if (bus.i_mem_ready) begin
                r_mem_ren <= 1'b0;
                r_mem_wen <= 1'b0;
                r_state   <= S_WAIT;
            end
        end else if (w_grant_point) begin
            if (w_grant_d) begin
                r_owner_d   <= 1'b1;
                r_mem_addr  <= bus.i_d_addr & C_WORD_MASK;
                r_mem_wdata <= bus.i_d_wdata;
                r_mem_mask  <= bus.i_d_mask;
                // An illegal request never reaches memory; it is answered
                // with an error response on the next cycle instead.
                r_mem_ren   <= bus.i_d_ren && !w_d_illegal;
                r_mem_wen   <= bus.i_d_wen && !w_d_illegal;
                r_state     <= w_d_illegal ? S_ERR : S_ISSUE;
                // Streak only grows while fetch is actually being held off;
                // it can never pass C_MAX_BURST because fetch wins there.
                r_streak    <= bus.i_if_req ? (r_streak + 4'd1) : 4'd0;
            end else if (w_grant_if) begin
                r_owner_d   <= 1'b0;
                r_mem_addr  <= bus.i_if_addr & C_WORD_MASK;
                r_mem_wdata <= 32'h0;
                r_mem_mask  <= 4'b1111;
                r_mem_ren   <= 1'b1;
                r_mem_wen   <= 1'b0;
                r_state     <= S_ISSUE;
                r_streak    <= 4'd0;
            end else begin
                r_state     <= S_IDLE;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mem_arbiter
//  Description : Directed bench for mem_arbiter. Requester agents and a
//                configurable-latency memory model are stepped once per clock
//                from a single process; expected responses are queued at
//                accept time and compared when the responses appear.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_arbiter;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    mem_arbiter_if bus ();

    mem_arbiter #(.MAX_DATA_BURST(4)) dut (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus)
    );

    typedef struct {
        logic [31:0] addr;
        logic        ren;
        logic        wen;
        logic [31:0] wdata;
        logic [3:0]  mask;
    } dreq_t;

    logic [31:0] if_todo [$];
    dreq_t       d_todo  [$];
    logic [31:0] if_exp  [$];
    logic [32:0] d_exp   [$];   // {err, rdata}
    logic [31:0] memarr  [logic [31:0]];
    string       glog;

    int tests = 0;
    int fails = 0;

    int          mem_stall_cfg = 0;
    int          mem_lat_cfg   = 1;
    int          stall_cnt     = 0;
    int          lat_cnt       = 0;
    bit          mem_pend      = 1'b0;
    logic [31:0] resp_data;
    int          if_valid_cnt  = 0;
    int          d_valid_cnt   = 0;
    bit          cmd_seen      = 1'b0;

    function automatic logic [31:0] rd(input logic [31:0] a);
        if (memarr.exists(a)) return memarr[a];
        return a ^ 32'h5A5A_0000;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic mem_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] m);
        logic [31:0] w;
        w = rd(a);
        for (int b = 0; b < 4; b++)
            if (m[b]) w[8*b +: 8] = d[8*b +: 8];
        memarr[a] = w;
    endtask

    // One clock: drive requesters and memory at negedge, observe 1 ns later.
    task automatic step();
        dreq_t r;
        @(negedge clk);
        bus.i_if_req  = (if_todo.size() > 0);
        bus.i_if_addr = (if_todo.size() > 0) ? if_todo[0] : 32'h0;
        if (d_todo.size() > 0) begin
            r = d_todo[0];
            bus.i_d_req   = 1'b1;
            bus.i_d_addr  = r.addr;
            bus.i_d_ren   = r.ren;
            bus.i_d_wen   = r.wen;
            bus.i_d_wdata = r.wdata;
            bus.i_d_mask  = r.mask;
        end else begin
            bus.i_d_req   = 1'b0;
            bus.i_d_addr  = 32'h0;
            bus.i_d_ren   = 1'b0;
            bus.i_d_wen   = 1'b0;
            bus.i_d_wdata = 32'h0;
            bus.i_d_mask  = 4'h0;
        end
        bus.i_mem_ready = 1'b0;
        bus.i_mem_valid = 1'b0;
        bus.i_mem_rdata = 32'hBAD0_0BAD;
        if (mem_pend) begin
            lat_cnt--;
            if (lat_cnt == 0) begin
                bus.i_mem_valid = 1'b1;
                bus.i_mem_rdata = resp_data;
                mem_pend = 1'b0;
            end
        end else if (bus.o_mem_ren || bus.o_mem_wen) begin
            cmd_seen = 1'b1;
            if (stall_cnt < mem_stall_cfg) begin
                stall_cnt++;
            end else begin
                bus.i_mem_ready = 1'b1;
                stall_cnt = 0;
                mem_pend  = 1'b1;
                lat_cnt   = mem_lat_cfg;
                resp_data = bus.o_mem_ren ? rd(bus.o_mem_addr) : 32'h0;
                if (bus.o_mem_wen) mem_write(bus.o_mem_addr, bus.o_mem_wdata, bus.o_mem_mask);
            end
        end
        #1;
        if (bus.o_if_ready) begin
            if (if_todo.size() == 0) chk("if_ready_spurious", 1, 0);
            else begin
                glog = {glog, "I"};
                if_exp.push_back(rd(if_todo[0] & 32'hFFFF_FFFC));
                void'(if_todo.pop_front());
            end
        end
        if (bus.o_d_ready) begin
            if (d_todo.size() == 0) chk("d_ready_spurious", 1, 0);
            else begin
                r = d_todo.pop_front();
                glog = {glog, "D"};
                if (r.ren && r.wen) d_exp.push_back({1'b1, 32'h0});
                else if (r.ren)     d_exp.push_back({1'b0, rd(r.addr & 32'hFFFF_FFFC)});
                else                d_exp.push_back({1'b0, 32'h0});
            end
        end
        if (bus.o_if_valid) begin
            if_valid_cnt++;
            if (if_exp.size() == 0) chk("if_valid_unexpected", 1, 0);
            else chk("if_rdata", bus.o_if_rdata, if_exp.pop_front());
        end else begin
            chk("if_rdata_gated", bus.o_if_rdata, 0);
        end
        if (bus.o_d_valid) begin
            d_valid_cnt++;
            if (d_exp.size() == 0) chk("d_valid_unexpected", 1, 0);
            else chk("d_resp", {bus.o_d_err, bus.o_d_rdata}, d_exp.pop_front());
        end else begin
            chk("d_rdata_gated", {bus.o_d_err, bus.o_d_rdata}, 0);
        end
    endtask

    task automatic drain(input string tag, input int max);
        int n;
        n = 0;
        while ((if_todo.size() > 0 || d_todo.size() > 0 || if_exp.size() > 0 ||
                d_exp.size() > 0 || mem_pend) && n < max) begin
            step();
            n++;
        end
        chk({tag, "_drained"}, (if_todo.size() == 0 && d_todo.size() == 0 &&
                                if_exp.size() == 0 && d_exp.size() == 0), 1);
    endtask

    initial begin
        int base_if;
        rst = 1'b1;
        bus.i_if_req = 1'b0;  bus.i_if_addr = 32'h0;
        bus.i_d_req  = 1'b0;  bus.i_d_addr  = 32'h0;
        bus.i_d_ren  = 1'b0;  bus.i_d_wen   = 1'b0;
        bus.i_d_wdata = 32'h0; bus.i_d_mask = 4'h0;
        bus.i_mem_ready = 1'b0; bus.i_mem_valid = 1'b0; bus.i_mem_rdata = 32'h0;
        glog = "";

        // ---- reset state
        repeat (2) @(negedge clk);
        #1;
        chk("rst_busy", bus.o_busy, 0);
        chk("rst_mem_cmd", {bus.o_mem_ren, bus.o_mem_wen}, 0);
        chk("rst_mem_fields", {bus.o_mem_addr, bus.o_mem_wdata, bus.o_mem_mask}, 0);
        chk("rst_handshake", {bus.o_if_ready, bus.o_if_valid, bus.o_d_ready,
                              bus.o_d_valid, bus.o_d_err}, 0);
        rst = 1'b0;

        // ---- single fetch, immediate memory
        memarr[32'h0000_1004] = 32'hDEAD_BEEF;
        if_todo.push_back(32'h0000_1006);
        step();
        chk("f1_ready_c0", bus.o_if_ready, 1);
        chk("f1_nocmd_c0", bus.o_mem_ren, 0);
        step();
        chk("f1_cmd_c1", {bus.o_mem_ren, bus.o_mem_wen}, 2'b10);
        chk("f1_addr_c1", bus.o_mem_addr, 32'h0000_1004);
        chk("f1_mask_c1", bus.o_mem_mask, 4'b1111);
        step();
        chk("f1_valid_c2", bus.o_if_valid, 1);
        chk("f1_rdata_c2", bus.o_if_rdata, 32'hDEAD_BEEF);
        step();
        chk("f1_idle", bus.o_busy, 0);

        // ---- simultaneous fetch + store: data first
        glog = "";
        memarr[32'h20] = 32'hFFFF_FF00;
        d_todo.push_back('{32'h20, 1'b0, 1'b1, 32'h11, 4'b0001});
        if_todo.push_back(32'h40);
        step();
        chk("fd_dready", {bus.o_d_ready, bus.o_if_ready}, 2'b10);
        step();
        chk("fd_store_cmd", {bus.o_mem_ren, bus.o_mem_wen}, 2'b01);
        chk("fd_store_fields", {bus.o_mem_addr, bus.o_mem_wdata, bus.o_mem_mask},
            {32'h20, 32'h11, 4'b0001});
        step();
        chk("fd_store_valid_and_fetch_grant", {bus.o_d_valid, bus.o_if_ready}, 2'b11);
        step();
        chk("fd_fetch_cmd", {bus.o_mem_ren, bus.o_mem_addr}, {1'b1, 32'h40});
        step();
        chk("fd_fetch_valid", bus.o_if_valid, 1);
        chk("fd_mem_written", memarr[32'h20], 32'hFFFF_FF11);
        tests++;
        assert (glog == "DI") else begin
            fails++; $error("FAIL fd_order: observed %s expected DI", glog);
        end
        drain("fd", 20);

        // ---- starvation guard
        glog = "";
        if_todo.push_back(32'h300);
        for (int i = 0; i < 6; i++)
            d_todo.push_back('{32'h400 + 32'(4*i), 1'b1, 1'b0, 32'h0, 4'b1111});
        drain("starve", 60);
        tests++;
        assert (glog == "DDDDIDD") else begin
            fails++; $error("FAIL starve_order: observed %s expected DDDDIDD", glog);
        end

        // ---- illegal data request
        cmd_seen = 1'b0;
        d_todo.push_back('{32'h50, 1'b1, 1'b1, 32'hFFFF_FFFF, 4'b1111});
        step();
        chk("ill_ready", bus.o_d_ready, 1);
        step();
        chk("ill_resp", {bus.o_d_valid, bus.o_d_err, bus.o_d_rdata}, {2'b11, 32'h0});
        step();
        chk("ill_idle", {bus.o_busy, bus.o_d_valid}, 0);
        chk("ill_no_mem_cmd", cmd_seen, 0);

        // ---- memory stalls 3 cycles, response 2 cycles after accept
        mem_stall_cfg = 3;
        mem_lat_cfg   = 2;
        d_valid_cnt   = 0;
        d_todo.push_back('{32'h82, 1'b1, 1'b0, 32'h0, 4'b1111});
        step();
        chk("stall_ready", {bus.o_d_ready, bus.o_busy}, 2'b10);
        for (int k = 1; k <= 4; k++) begin
            step();
            chk("stall_cmd_held", {bus.o_mem_ren, bus.o_mem_wen, bus.o_mem_addr,
                                   bus.o_mem_mask, bus.o_busy, bus.o_d_valid},
                {2'b10, 32'h80, 4'b1111, 1'b1, 1'b0});
        end
        step();
        chk("stall_cmd_dropped", {bus.o_mem_ren, bus.o_busy, bus.o_d_valid}, 3'b010);
        step();
        chk("stall_resp", {bus.o_d_valid, bus.o_busy}, 2'b11);
        step();
        step();
        chk("stall_idle", bus.o_busy, 0);
        chk("stall_one_resp", d_valid_cnt, 1);
        mem_stall_cfg = 0;
        mem_lat_cfg   = 1;

        // ---- async reset during WAIT
        mem_lat_cfg = 4;
        if_todo.push_back(32'h100);
        step();
        step();
        step();
        step();
        chk("arst_in_wait", {bus.o_busy, bus.o_mem_ren}, 2'b10);
        rst = 1'b1;
        #1;
        chk("arst_busy", bus.o_busy, 0);
        chk("arst_mem", {bus.o_mem_ren, bus.o_mem_wen, bus.o_mem_addr,
                         bus.o_mem_wdata, bus.o_mem_mask}, 0);
        chk("arst_handshake", {bus.o_if_ready, bus.o_if_valid, bus.o_d_ready,
                               bus.o_d_valid, bus.o_d_err}, 0);
        if_exp.delete();
        step();
        rst = 1'b0;
        base_if = if_valid_cnt;
        step();
        chk("arst_late_valid_ignored", {bus.o_if_valid, bus.o_d_valid, bus.o_busy}, 0);
        chk("arst_no_if_resp", if_valid_cnt, base_if);
        mem_lat_cfg = 1;
        memarr[32'h204] = 32'hCAFE_F00D;
        if_todo.push_back(32'h204);
        step();
        chk("arst_new_ready", bus.o_if_ready, 1);
        drain("arst_new", 20);
        chk("arst_new_served", if_valid_cnt, base_if + 1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
